// File: rtl/sid_mac_sched.sv
// sid_mac_sched: shares one external signed*unsigned multiplier across the
// three voice*envelope multiplies and the mix*volume multiply of a SID core.
// One four-slot sequence runs per CLKen tick.
// Optional feature: define SID_MAC_ROUND_EN for round-half-up slicing of the
// products. Without it the products are truncated toward minus infinity.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for CLKen
// S_ISSUE | driving slot operands onto MUL_A/MUL_B, one slot per cycle
// S_DRAIN | waiting MUL_LAT cycles for the last products to arrive
// S_DONE  | all results registered; VALID pulses, new start accepted
module sid_mac_sched #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CLKen,
  input  logic [11:0] VOICE0,
  input  logic [11:0] VOICE1,
  input  logic [11:0] VOICE2,
  input  logic [7:0]  ENV0,
  input  logic [7:0]  ENV1,
  input  logic [7:0]  ENV2,
  input  logic [15:0] PRE_VOL,
  input  logic [3:0]  VOL,
  output logic [15:0] MUL_A,
  output logic [15:0] MUL_B,
  input  logic [31:0] MUL_P,
  output logic [15:0] AMP0,
  output logic [15:0] AMP1,
  output logic [15:0] AMP2,
  output logic [15:0] OUTPUT,
  output logic        VALID,
  output logic        BUSY,
  output logic        OVERRUN
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Step counter runs 0..3 through ISSUE and continues through DRAIN.
  localparam logic [2:0] LAST_STEP = 3'(3 + MUL_LAT);

`ifdef SID_MAC_ROUND_EN
  localparam logic [31:0] RND_VOICE = 32'h0000_0080;
  localparam logic [31:0] RND_VOL   = 32'h0000_0008;
`else
  localparam logic [31:0] RND_VOICE = 32'h0000_0000;
  localparam logic [31:0] RND_VOL   = 32'h0000_0000;
`endif

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic        start;
  logic        over_set;
  logic        overrun_q;

  logic [11:0] voice_q [3];
  logic [7:0]  env_q   [3];
  logic [15:0] pre_vol_q;
  logic [3:0]  vol_q;

  logic [15:0] amp_q [3];
  logic [15:0] out_q;

  logic [3:0]  cap_diff;
  logic        cap_en;
  logic [1:0]  cap_slot;
  logic [31:0] sum_voice;
  logic [31:0] sum_vol;
  logic        unused_bits;

  // Next-state logic: sequence stepping, start acceptance and overrun detection.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    start    = 1'b0;
    over_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CLKen) start = 1'b1;
      end
      S_ISSUE: begin
        step_d = step_q + 3'd1;
        if (CLKen) over_set = 1'b1;
        if (step_q == 3'd3) state_d = (MUL_LAT == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        step_d = step_q + 3'd1;
        if (CLKen) over_set = 1'b1;
        if (step_q == LAST_STEP) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (CLKen) start = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      state_d = S_ISSUE;
      step_d  = 3'd0;
    end
  end

  // State register and operand latch taken at the start tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      step_q    <= 3'd0;
      overrun_q <= 1'b0;
      pre_vol_q <= 16'h0;
      vol_q     <= 4'h0;
      for (int i = 0; i < 3; i++) begin
        voice_q[i] <= 12'h0;
        env_q[i]   <= 8'h0;
      end
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      if (over_set) overrun_q <= 1'b1;
      if (start) begin
        voice_q[0] <= VOICE0;
        voice_q[1] <= VOICE1;
        voice_q[2] <= VOICE2;
        env_q[0]   <= ENV0;
        env_q[1]   <= ENV1;
        env_q[2]   <= ENV2;
        pre_vol_q  <= PRE_VOL;
        vol_q      <= VOL;
      end
    end
  end

  // Operand mux: slot k operands during ISSUE step k, zero otherwise.
  always_comb begin
    MUL_A = 16'h0;
    MUL_B = 16'h0;
    if (state_q == S_ISSUE) begin
      case (step_q[1:0])
        2'd0: begin MUL_A = {voice_q[0], 4'h0}; MUL_B = {8'h0, env_q[0]}; end
        2'd1: begin MUL_A = {voice_q[1], 4'h0}; MUL_B = {8'h0, env_q[1]}; end
        2'd2: begin MUL_A = {voice_q[2], 4'h0}; MUL_B = {8'h0, env_q[2]}; end
        default: begin MUL_A = pre_vol_q; MUL_B = {12'h0, vol_q}; end
      endcase
    end
  end

  // The product for slot k shows up MUL_LAT steps after its issue step; a
  // non-negative difference selects which output register to load.
  always_comb begin
    cap_diff  = {1'b0, step_q} - 4'(MUL_LAT);
    cap_en    = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && !cap_diff[3];
    cap_slot  = cap_diff[1:0];
    sum_voice = MUL_P + RND_VOICE;
    sum_vol   = MUL_P + RND_VOL;
  end

  assign unused_bits = ^{cap_diff[2], sum_voice[31:24], sum_voice[7:0],
                         sum_vol[31:20], sum_vol[3:0]};

  // Result capture; each output holds until its own slot is captured again.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 3; i++) amp_q[i] <= 16'h0;
      out_q <= 16'h0;
    end else if (cap_en) begin
      case (cap_slot)
        2'd0: amp_q[0] <= sum_voice[23:8];
        2'd1: amp_q[1] <= sum_voice[23:8];
        2'd2: amp_q[2] <= sum_voice[23:8];
        default: out_q <= sum_vol[19:4];
      endcase
    end
  end

  assign AMP0    = amp_q[0];
  assign AMP1    = amp_q[1];
  assign AMP2    = amp_q[2];
  assign OUTPUT  = out_q;
  assign VALID   = (state_q == S_DONE);
  assign BUSY    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_sid_mac_sched.sv
// Testbench for sid_mac_sched: four instances with MUL_LAT 0..3 share the
// stimulus; each has its own latency-accurate multiplier model. Directed
// scenarios observe the MUL_LAT=1 instance.
module tb_sid_mac_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clken;
  logic [11:0] v0, v1, v2;
  logic [7:0]  e0, e1, e2;
  logic [15:0] pre_vol;
  logic [3:0]  vol;

  logic [15:0] mul_a [4];
  logic [15:0] mul_b [4];
  logic [15:0] amp0 [4];
  logic [15:0] amp1 [4];
  logic [15:0] amp2 [4];
  logic [15:0] outv [4];
  logic        valid [4];
  logic        busy [4];
  logic        ovr [4];

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    sa = {{16{a[15]}}, a};
    sb = {16'h0, b};
    return sa * sb;
  endfunction

  function automatic logic [15:0] amp_of(input logic [31:0] p);
    logic [31:0] s;
`ifdef SID_MAC_ROUND_EN
    s = p + 32'h80;
`else
    s = p;
`endif
    return s[23:8];
  endfunction

  function automatic logic [15:0] out_of(input logic [31:0] p);
    logic [31:0] s;
`ifdef SID_MAC_ROUND_EN
    s = p + 32'h8;
`else
    s = p;
`endif
    return s[19:4];
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [31:0] pr;
    logic [31:0] p_w;
    logic [31:0] pipe [3];
    assign pr = prod(mul_a[g], mul_b[g]);
    always_ff @(posedge clk) begin
      pipe[0] <= pr;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    if (g == 0) begin : g_comb
      assign p_w = pr;
    end else begin : g_pipe
      assign p_w = pipe[g-1];
    end
    sid_mac_sched #(.MUL_LAT(g)) u_dut (
      .CLK(clk), .RST(rst), .CLKen(clken),
      .VOICE0(v0), .VOICE1(v1), .VOICE2(v2),
      .ENV0(e0), .ENV1(e1), .ENV2(e2),
      .PRE_VOL(pre_vol), .VOL(vol),
      .MUL_A(mul_a[g]), .MUL_B(mul_b[g]), .MUL_P(p_w),
      .AMP0(amp0[g]), .AMP1(amp1[g]), .AMP2(amp2[g]), .OUTPUT(outv[g]),
      .VALID(valid[g]), .BUSY(busy[g]), .OVERRUN(ovr[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clken = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Pulses CLKen in the current cycle t and waits (bounded) for VALID on the
  // MUL_LAT=1 instance. cyc is n where VALID was seen at t+n, 0 on timeout.
  task automatic start_and_wait(output int cyc);
    cyc = 0;
    clken = 1'b1;
    tick();
    clken = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      if (valid[1]) begin
        cyc = n;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clken = 1'b1;
    tick();
    tick();
    tick();
    for (int g = 0; g < 4; g++) begin
      checks++;
      if ({amp0[g], amp1[g], amp2[g], outv[g], mul_a[g], mul_b[g]} !== 96'h0 ||
          {valid[g], busy[g], ovr[g]} !== 3'b000) begin
        errors++;
        $display("FAIL reset lat=%0d amps=%h %h %h out=%h a=%h b=%h vbo=%b%b%b exp all 0",
                 g, amp0[g], amp1[g], amp2[g], outv[g], mul_a[g], mul_b[g],
                 valid[g], busy[g], ovr[g]);
      end
    end
    clken = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sweep();
    logic [11:0] sv [3];
    logic [7:0]  se [3];
    logic [15:0] spre, ea, eb;
    logic [3:0]  svol;
    logic [15:0] exp_amp [3];
    logic [15:0] exp_out;
    for (int it = 0; it < 4; it++) begin
      v0 = 12'($urandom); v1 = 12'($urandom); v2 = 12'($urandom);
      e0 = 8'($urandom);  e1 = 8'($urandom);  e2 = 8'($urandom);
      pre_vol = 16'($urandom); vol = 4'($urandom);
      if (it == 0) begin v0 = 12'h800; e0 = 8'hFF; pre_vol = 16'h8000; vol = 4'hF; end
      sv[0] = v0; sv[1] = v1; sv[2] = v2;
      se[0] = e0; se[1] = e1; se[2] = e2;
      spre = pre_vol; svol = vol;
      for (int k = 0; k < 3; k++) exp_amp[k] = amp_of(prod({sv[k], 4'h0}, {8'h0, se[k]}));
      exp_out = out_of(prod(spre, {12'h0, svol}));
      clken = 1'b1;
      tick();
      clken = 1'b0;
      v0 = ~v0; v1 = ~v1; v2 = ~v2; e0 = ~e0; e1 = ~e1; e2 = ~e2;
      pre_vol = ~pre_vol; vol = ~vol;
      for (int n = 1; n <= 8; n++) begin
        if (n <= 3) begin
          ea = {sv[n-1], 4'h0}; eb = {8'h0, se[n-1]};
        end else if (n == 4) begin
          ea = spre; eb = {12'h0, svol};
        end else begin
          ea = 16'h0; eb = 16'h0;
        end
        for (int g = 0; g < 4; g++) begin
          checks++;
          if (mul_a[g] !== ea || mul_b[g] !== eb) begin
            errors++;
            $display("FAIL sweep_operands lat=%0d cyc=t+%0d got a=%h b=%h exp a=%h b=%h",
                     g, n, mul_a[g], mul_b[g], ea, eb);
          end
          checks++;
          if (valid[g] !== (n == 5 + g) || busy[g] !== (n <= 4 + g)) begin
            errors++;
            $display("FAIL sweep_handshake lat=%0d cyc=t+%0d got valid=%b busy=%b exp valid=%b busy=%b",
                     g, n, valid[g], busy[g], (n == 5 + g), (n <= 4 + g));
          end
          if (n == 5 + g) begin
            checks++;
            if (amp0[g] !== exp_amp[0] || amp1[g] !== exp_amp[1] ||
                amp2[g] !== exp_amp[2] || outv[g] !== exp_out) begin
              errors++;
              $display("FAIL sweep_results lat=%0d got %h %h %h out=%h exp %h %h %h out=%h",
                       g, amp0[g], amp1[g], amp2[g], outv[g],
                       exp_amp[0], exp_amp[1], exp_amp[2], exp_out);
            end
          end
        end
        if (n < 8) tick();
      end
    end
    tick();
  endtask

  task automatic test_directed();
    int cyc;
    do_reset();
    v0 = 12'h7FF; e0 = 8'hFF; v1 = 12'h000; e1 = 8'h55; v2 = 12'h000; e2 = 8'hAA;
    pre_vol = 16'h1000; vol = 4'hF;
    start_and_wait(cyc);
    checks++;
    if (cyc !== 6) begin
      errors++;
      $display("FAIL directed_valid_time got t+%0d exp t+6", cyc);
    end
    checks++;
    if (amp0[1] !== 16'h7F70 || amp1[1] !== 16'h0 || amp2[1] !== 16'h0 || outv[1] !== 16'h0F00) begin
      errors++;
      $display("FAIL directed_values got %h %h %h out=%h exp 7f70 0000 0000 out=0f00",
               amp0[1], amp1[1], amp2[1], outv[1]);
    end
    tick();
    tick();
    checks++;
    if (amp0[1] !== 16'h7F70 || outv[1] !== 16'h0F00 || valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL directed_hold got amp0=%h out=%h valid=%b exp 7f70 0f00 0",
               amp0[1], outv[1], valid[1]);
    end
  endtask

  task automatic test_sign();
    int cyc;
    logic [15:0] exp_neg_small;
    v1 = 12'h800; e1 = 8'h80;
    start_and_wait(cyc);
    checks++;
    if (cyc !== 6 || amp1[1] !== 16'hC000) begin
      errors++;
      $display("FAIL sign_min got amp1=%h cyc=%0d exp c000 cyc=6", amp1[1], cyc);
    end
    tick();
`ifdef SID_MAC_ROUND_EN
    exp_neg_small = 16'h0000;
`else
    exp_neg_small = 16'hFFFF;
`endif
    v1 = 12'hFFF; e1 = 8'h01;
    start_and_wait(cyc);
    checks++;
    if (cyc !== 6 || amp1[1] !== exp_neg_small) begin
      errors++;
      $display("FAIL sign_minus1x1 got amp1=%h cyc=%0d exp %h cyc=6", amp1[1], cyc, exp_neg_small);
    end
    tick();
    v1 = 12'hFFF; e1 = 8'h08;
    start_and_wait(cyc);
    checks++;
    if (cyc !== 6 || amp1[1] !== exp_neg_small) begin
      errors++;
      $display("FAIL sign_minus1x8 got amp1=%h cyc=%0d exp %h cyc=6", amp1[1], cyc, exp_neg_small);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int vcnt;
    do_reset();
    v0 = 12'h7FF; e0 = 8'hFF; v1 = 12'h123; e1 = 8'h40; v2 = 12'h000; e2 = 8'h00;
    pre_vol = 16'h1000; vol = 4'hF;
    clken = 1'b1;
    tick();
    clken = 1'b0;
    tick();
    tick();
    checks++;
    if (busy[1] !== 1'b1 || mul_a[1] !== 16'h0000 || amp0[1] !== 16'h7F70) begin
      errors++;
      $display("FAIL reset_mid_pre got busy=%b a=%h amp0=%h exp 1 0000 7f70",
               busy[1], mul_a[1], amp0[1]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({amp0[1], amp1[1], amp2[1], outv[1], mul_a[1], mul_b[1]} !== 96'h0 ||
        {valid[1], busy[1], ovr[1]} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_clear amps=%h %h %h out=%h a=%h b=%h vbo=%b%b%b exp all 0",
               amp0[1], amp1[1], amp2[1], outv[1], mul_a[1], mul_b[1], valid[1], busy[1], ovr[1]);
    end
    vcnt = 0;
    for (int n = 0; n < 5; n++) begin
      if (valid[1]) vcnt++;
      tick();
    end
    checks++;
    if (vcnt !== 0) begin
      errors++;
      $display("FAIL reset_mid_novalid got %0d pulses exp 0", vcnt);
    end
    v0 = 12'h100; e0 = 8'h10; v1 = 12'hF00; e1 = 8'h20; v2 = 12'h7FF; e2 = 8'h01;
    pre_vol = 16'hF000; vol = 4'h3;
    start_and_wait(cyc);
    checks++;
    if (cyc !== 6 || amp0[1] !== 16'h0100 || amp1[1] !== 16'hFE00 ||
        amp2[1] !== 16'h007F || outv[1] !== 16'hFD00) begin
      errors++;
      $display("FAIL reset_mid_rerun cyc=%0d got %h %h %h out=%h exp cyc=6 0100 fe00 007f out=fd00",
               cyc, amp0[1], amp1[1], amp2[1], outv[1]);
    end
    tick();
  endtask

  task automatic test_overrun();
    int cyc;
    int vcnt;
    do_reset();
    v0 = 12'h400; e0 = 8'h02; v1 = 12'h000; e1 = 8'h00; v2 = 12'h000; e2 = 8'h00;
    pre_vol = 16'h0010; vol = 4'h1;
    clken = 1'b1;
    tick();
    clken = 1'b0;
    tick();
    clken = 1'b1;
    v0 = 12'h7FF; e0 = 8'hFF; pre_vol = 16'h7FFF; vol = 4'hF;
    tick();
    clken = 1'b0;
    checks++;
    if (ovr[1] !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got %b exp 1", ovr[1]);
    end
    cyc = 0;
    for (int n = 3; n <= 12; n++) begin
      if (valid[1]) begin
        cyc = n;
        break;
      end
      tick();
    end
    checks++;
    if (cyc !== 6 || amp0[1] !== 16'h0080 || outv[1] !== 16'h0001) begin
      errors++;
      $display("FAIL overrun_first_inputs cyc=%0d amp0=%h out=%h exp cyc=6 0080 0001",
               cyc, amp0[1], outv[1]);
    end
    vcnt = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (valid[1]) vcnt++;
    end
    checks++;
    if (vcnt !== 0 || ovr[1] !== 1'b1 || amp0[1] !== 16'h0080) begin
      errors++;
      $display("FAIL overrun_sticky got pulses=%0d ovr=%b amp0=%h exp 0 1 0080",
               vcnt, ovr[1], amp0[1]);
    end
  endtask

  task automatic test_back_to_back();
    int vcnt;
    do_reset();
    v0 = 12'h010; e0 = 8'h10; v1 = 12'h000; e1 = 8'h00; v2 = 12'h000; e2 = 8'h00;
    pre_vol = 16'h0100; vol = 4'h2;
    clken = 1'b1;
    tick();
    clken = 1'b0;
    vcnt = 0;
    for (int n = 1; n <= 16; n++) begin
      if (valid[1]) vcnt++;
      if (n == 6) begin
        checks++;
        if (valid[1] !== 1'b1 || amp0[1] !== 16'h0010 || outv[1] !== 16'h0020) begin
          errors++;
          $display("FAIL b2b_first got valid=%b amp0=%h out=%h exp 1 0010 0020",
                   valid[1], amp0[1], outv[1]);
        end
        clken = 1'b1;
        v0 = 12'hFF0; e0 = 8'h20; pre_vol = 16'hFF00; vol = 4'h4;
      end
      if (n == 7) begin
        clken = 1'b0;
        checks++;
        if (busy[1] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_restart got busy=%b exp 1", busy[1]);
        end
      end
      if (n == 12) begin
        checks++;
        if (valid[1] !== 1'b1 || amp0[1] !== 16'hFFE0 || outv[1] !== 16'hFFC0) begin
          errors++;
          $display("FAIL b2b_second got valid=%b amp0=%h out=%h exp 1 ffe0 ffc0",
                   valid[1], amp0[1], outv[1]);
        end
      end
      tick();
    end
    checks++;
    if (vcnt !== 2 || ovr[1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count got pulses=%0d ovr=%b exp 2 0", vcnt, ovr[1]);
    end
  endtask

  initial begin
    rst = 1'b1; clken = 1'b0;
    v0 = '0; v1 = '0; v2 = '0; e0 = '0; e1 = '0; e2 = '0; pre_vol = '0; vol = '0;
    test_reset();
    test_sweep();
    test_directed();
    test_sign();
    test_reset_mid();
    test_overrun();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
